// File: rtl/ssd1306_write_sequencer.sv
// SSD1306 command/data byte sequencer: decodes the command stream, tracks the
// page/column cursor and expands each data byte into eight framebuffer pixel writes.
module ssd1306_write_sequencer #(
   parameter int DATA_WIDTH = 2,
   parameter int ADDR_WIDTH = 13
) (
   input  logic                  CLK25MHz,
   input  logic                  reset,
   input  logic                  byte_valid,
   input  logic                  byte_dc,
   input  logic [7:0]            byte_data,
   output logic                  byte_ready,
   output logic                  fb_we,
   output logic [ADDR_WIDTH-1:0] fb_addr,
   output logic [DATA_WIDTH-1:0] fb_din,
   output logic                  disp_on,
   output logic                  invert
);

   typedef enum logic [1:0] {S_IDLE, S_ARG, S_WRITE} state_t;

   state_t     r_state, w_next_state, w_decode_state;
   logic [1:0] r_mode;
   logic [6:0] r_col, r_col_start, r_col_end, r_arg1;
   logic [2:0] r_page, r_page_start, r_page_end;
   logic [2:0] r_bitcnt;
   logic [7:0] r_data, r_opcode;
   logic [1:0] r_argcnt;
   logic       r_disp_on, r_invert;

   logic       w_accept, w_burst_last;
   logic [1:0] w_nargs;
   logic [6:0] w_col_step, w_adv_col;
   logic [2:0] w_page_step, w_adv_page;

   assign w_accept     = byte_valid && byte_ready;
   assign w_burst_last = (r_state == S_WRITE) && (r_bitcnt == 3'd7);
   assign w_col_step   = (r_col == r_col_end) ? r_col_start : r_col + 7'd1;
   assign w_page_step  = (r_page == r_page_end) ? r_page_start : r_page + 3'd1;
   assign disp_on      = r_disp_on;
   assign invert       = r_invert;

   always_comb begin
      case (byte_data)
         8'h21, 8'h22:                                    w_nargs = 2'd2;
         8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9,
         8'hDA, 8'hDB:                                    w_nargs = 2'd1;
         default:                                         w_nargs = 2'd0;
      endcase
   end

   // Cursor after the burst that is finishing this cycle (unchanged otherwise).
   always_comb begin
      w_adv_col  = r_col;
      w_adv_page = r_page;
      if (w_burst_last) begin
         case (r_mode)
            2'd0: begin
               w_adv_col = w_col_step;
               if (r_col == r_col_end) w_adv_page = w_page_step;
            end
            2'd1: begin
               w_adv_page = w_page_step;
               if (r_page == r_page_end) w_adv_col = w_col_step;
            end
            default: w_adv_col = r_col + 7'd1;
         endcase
      end
   end

   always_ff @(posedge CLK25MHz) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      w_decode_state = byte_dc ? S_WRITE : ((w_nargs != 2'd0) ? S_ARG : S_IDLE);
      w_next_state   = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next_state = w_decode_state;
         S_ARG:   if (w_accept)
                     w_next_state = byte_dc ? S_WRITE : ((r_argcnt == 2'd1) ? S_IDLE : S_ARG);
         S_WRITE: if (r_bitcnt == 3'd7) w_next_state = w_accept ? w_decode_state : S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      byte_ready = (r_state != S_WRITE) || (r_bitcnt == 3'd7);
      fb_we      = (r_state == S_WRITE);
      fb_addr    = '0;
      fb_din     = '0;
      if (fb_we) begin
         fb_addr = ADDR_WIDTH'({r_page, r_col, r_bitcnt});
         fb_din  = DATA_WIDTH'(r_data[r_bitcnt]);
      end
   end

   always_ff @(posedge CLK25MHz) begin
      if (reset) begin
         r_mode       <= 2'd2;
         r_col        <= '0;
         r_page       <= '0;
         r_col_start  <= '0;
         r_col_end    <= 7'd127;
         r_page_start <= '0;
         r_page_end   <= 3'd7;
         r_bitcnt     <= '0;
         r_data       <= '0;
         r_opcode     <= '0;
         r_argcnt     <= '0;
         r_arg1       <= '0;
         r_disp_on    <= 1'b0;
         r_invert     <= 1'b0;
      end else begin
         r_col  <= w_adv_col;
         r_page <= w_adv_page;
         if (r_state == S_WRITE) r_bitcnt <= r_bitcnt + 3'd1;
         if (w_accept) begin
            if (byte_dc) begin
               r_data   <= byte_data;
               r_bitcnt <= '0;
               r_argcnt <= '0;
            end else if (r_state == S_ARG) begin
               if (r_argcnt == 2'd2) begin
                  r_arg1   <= byte_data[6:0];
                  r_argcnt <= 2'd1;
               end else begin
                  r_argcnt <= '0;
                  case (r_opcode)
                     8'h20: r_mode <= (byte_data[1:0] == 2'd3) ? 2'd2 : byte_data[1:0];
                     8'h21: begin
                        r_col_start <= r_arg1;
                        r_col_end   <= byte_data[6:0];
                        r_col       <= r_arg1;
                     end
                     8'h22: begin
                        r_page_start <= r_arg1[2:0];
                        r_page_end   <= byte_data[2:0];
                        r_page       <= r_arg1[2:0];
                     end
                     default: ;
                  endcase
               end
            end else begin
               r_opcode <= byte_data;
               r_argcnt <= w_nargs;
               if (byte_data[7:4] == 4'h0)         r_col  <= {w_adv_col[6:4], byte_data[3:0]};
               else if (byte_data[7:4] == 4'h1)    r_col  <= {byte_data[2:0], w_adv_col[3:0]};
               else if (byte_data[7:3] == 5'h16)   r_page <= byte_data[2:0];
               case (byte_data)
                  8'hAE: r_disp_on <= 1'b0;
                  8'hAF: r_disp_on <= 1'b1;
                  8'hA6: r_invert  <= 1'b0;
                  8'hA7: r_invert  <= 1'b1;
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_ssd1306_write_sequencer.sv
// Randomised and directed bench for ssd1306_write_sequencer against a byte-level
// reference model that predicts every framebuffer write.
module tb_ssd1306_write_sequencer;

   localparam int DW = 2;
   localparam int AW = 13;

   logic          clk = 1'b0;
   logic          reset;
   logic          byte_valid, byte_dc;
   logic [7:0]    byte_data;
   logic          byte_ready, fb_we, disp_on, invert;
   logic [AW-1:0] fb_addr;
   logic [DW-1:0] fb_din;

   ssd1306_write_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .CLK25MHz  (clk),
      .reset     (reset),
      .byte_valid(byte_valid),
      .byte_dc   (byte_dc),
      .byte_data (byte_data),
      .byte_ready(byte_ready),
      .fb_we     (fb_we),
      .fb_addr   (fb_addr),
      .fb_din    (fb_din),
      .disp_on   (disp_on),
      .invert    (invert)
   );

   always #20 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: display state as plain integers, writes as a queue.
   int m_mode, m_col, m_page, m_cs, m_ce, m_ps, m_pe, m_disp, m_inv;
   int m_op, m_left, m_arg1;
   int exp_addr[$];
   int exp_din[$];

   function automatic void model_reset();
      m_mode = 2; m_col = 0; m_page = 0;
      m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7;
      m_disp = 0; m_inv = 0; m_op = 0; m_left = 0; m_arg1 = 0;
   endfunction

   function automatic int next_col();
      return (m_col == m_ce) ? m_cs : (m_col + 1) % 128;
   endfunction

   function automatic int next_page();
      return (m_page == m_pe) ? m_ps : (m_page + 1) % 8;
   endfunction

   function automatic void model_data(input int d);
      int nc, np;
      for (int b = 0; b < 8; b++) begin
         exp_addr.push_back(m_page * 1024 + m_col * 8 + b);
         exp_din.push_back((d >> b) & 1);
      end
      nc = next_col();
      np = next_page();
      case (m_mode)
         0: begin
            if (m_col == m_ce) m_page = np;
            m_col = nc;
         end
         1: begin
            if (m_page == m_pe) m_col = nc;
            m_page = np;
         end
         default: m_col = (m_col + 1) % 128;
      endcase
   endfunction

   function automatic void model_apply(input int dc, input int d);
      if (dc != 0) begin
         m_left = 0;
         model_data(d);
      end else if (m_left == 2) begin
         m_arg1 = d;
         m_left = 1;
      end else if (m_left == 1) begin
         m_left = 0;
         if (m_op == 'h20) m_mode = (d % 4 == 3) ? 2 : d % 4;
         if (m_op == 'h21) begin m_cs = m_arg1 % 128; m_ce = d % 128; m_col = m_cs; end
         if (m_op == 'h22) begin m_ps = m_arg1 % 8;   m_pe = d % 8;   m_page = m_ps; end
      end else begin
         m_op = d;
         if (d <= 'h0F)                  m_col  = (m_col / 16) * 16 + d;
         else if (d <= 'h1F)             m_col  = (d % 8) * 16 + m_col % 16;
         else if (d >= 'hB0 && d <= 'hB7) m_page = d - 'hB0;
         else if (d == 'hAE)             m_disp = 0;
         else if (d == 'hAF)             m_disp = 1;
         else if (d == 'hA6)             m_inv  = 0;
         else if (d == 'hA7)             m_inv  = 1;
         else if (d == 'h21 || d == 'h22) m_left = 2;
         else if (d == 'h20 || d == 'h81 || d == 'h8D || d == 'hA8 || d == 'hD3 ||
                  d == 'hD5 || d == 'hD9 || d == 'hDA || d == 'hDB) m_left = 1;
      end
   endfunction

   // Every write strobe must match the next predicted pixel write.
   always @(negedge clk) begin
      if (fb_we === 1'b1) begin
         if (exp_addr.size() == 0) check("spurious_fb_we", int'(fb_we), 0);
         else begin
            check("fb_addr", int'(fb_addr), exp_addr.pop_front());
            check("fb_din", int'(fb_din), exp_din.pop_front());
         end
      end
   end

   // Called at a falling edge; returns at the falling edge after acceptance.
   task automatic send(input int dc, input int d);
      int n = 0;
      byte_valid = 1'b1;
      byte_dc    = dc[0];
      byte_data  = d[7:0];
      while (!byte_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         check("byte_ready_timeout", n, 0);
         byte_valid = 1'b0;
         return;
      end
      @(posedge clk);
      model_apply(dc, d);
      @(negedge clk);
      byte_valid = 1'b0;
      check("disp_on", int'(disp_on), m_disp);
      check("invert", int'(invert), m_inv);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset      = 1'b1;
      byte_valid = 1'b0;
      exp_addr.delete();
      exp_din.delete();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_addr.size() != 0 || fb_we) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending_writes", exp_addr.size(), 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int low_cnt;
      reset = 1'b1; byte_valid = 1'b0; byte_dc = 1'b0; byte_data = '0;
      model_reset();
      do_reset();

      check("reset_byte_ready", int'(byte_ready), 1);
      check("reset_fb_we", int'(fb_we), 0);
      check("reset_fb_addr", int'(fb_addr), 0);
      check("reset_fb_din", int'(fb_din), 0);
      check("reset_disp_on", int'(disp_on), 0);
      check("reset_invert", int'(invert), 0);

      // Single byte: eight writes, ready low for exactly seven cycles.
      send(1, 'hA5);
      low_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (!byte_ready) low_cnt++;
         @(negedge clk);
      end
      check("ready_low_cycles", low_cnt, 7);
      send(1, 'h3C);
      drain();

      // Horizontal mode inside a 2x2 window in the bottom-right corner.
      do_reset();
      send(0, 'h20); send(0, 'h00);
      send(0, 'h21); send(0, 'h7E); send(0, 'h7F);
      send(0, 'h22); send(0, 'h06); send(0, 'h07);
      for (int i = 0; i < 5; i++) send(1, $urandom_range(0, 255));
      drain();

      // Vertical mode, window cols 0-1 pages 0-1.
      do_reset();
      send(0, 'h20); send(0, 'h01);
      send(0, 'h21); send(0, 'h00); send(0, 'h01);
      send(0, 'h22); send(0, 'h00); send(0, 'h01);
      for (int i = 0; i < 5; i++) send(1, $urandom_range(0, 255));
      drain();

      // Page mode column wrap from 127 to 0.
      do_reset();
      send(0, 'hB3); send(0, 'h0F); send(0, 'h17);
      send(1, 'h81); send(1, 'h7E);
      drain();

      // Data byte aborting a pending window command, then flag commands.
      do_reset();
      send(0, 'h20); send(0, 'h00);
      send(0, 'h21); send(1, 'h5A);
      send(1, 'hC3); send(1, 'h0F);
      send(0, 'hAF); send(0, 'hA7);
      drain();

      // Reset during the fourth write cycle of a burst.
      send(1, 'hFF);
      repeat (3) @(negedge clk);
      #1;
      reset = 1'b1;
      exp_addr.delete();
      exp_din.delete();
      model_reset();
      @(negedge clk);
      check("midreset_fb_we", int'(fb_we), 0);
      check("midreset_fb_addr", int'(fb_addr), 0);
      check("midreset_byte_ready", int'(byte_ready), 1);
      check("midreset_disp_on", int'(disp_on), 0);
      reset = 1'b0;
      @(negedge clk);
      send(1, 'h96);
      drain();

      // Randomised command/data stream, including back-to-back bytes.
      do_reset();
      for (int i = 0; i < 300; i++) begin
         send(($urandom_range(0, 99) < 35) ? 1 : 0, $urandom_range(0, 255));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
